seq_magnitude_comparator: RTL and testbench

//  Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands A and B.

---
 rtl/seq_magnitude_comparator.sv | 144 ++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans CHUNK bits per clock from the MSB side and stops at the first differing chunk.
// Optional two's-complement mode is compiled in with the CMP_SIGNED_EN macro (adds the signed_cmp port).
module seq_magnitude_comparator #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4,
   localparam int NCHUNK = WIDTH / CHUNK,
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
   input  logic             signed_cmp,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic             a_gt,
   output logic             b_gt,
   output logic             a_eq,
   output logic [IW:0]      n_cycles
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IW-1:0]    idx_q;
   logic [IW:0]      cnt_q;
   logic             out_valid_q;
   logic             a_gt_q;
   logic             b_gt_q;
   logic             a_eq_q;
   logic [IW:0]      n_cycles_q;
`ifdef CMP_SIGNED_EN
   logic             signed_q;
`endif

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic             a_wins;
   logic             b_wins;

   // Mux the chunk under inspection; with a single chunk idx_q stays 0.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx_q == i[IW-1:0]) begin
            a_chunk = a_q[i*CHUNK +: CHUNK];
            b_chunk = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   always_comb begin
      a_wins = (a_chunk > b_chunk);
      b_wins = (b_chunk > a_chunk);
`ifdef CMP_SIGNED_EN
      // Differing sign bits decide a signed compare on the first cycle: the non-negative operand is larger.
      if (signed_q && (cnt_q == '0) && (a_q[WIDTH-1] != b_q[WIDTH-1])) begin
         a_wins = ~a_q[WIDTH-1];
         b_wins = a_q[WIDTH-1];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         a_gt_q      <= 1'b0;
         b_gt_q      <= 1'b0;
         a_eq_q      <= 1'b0;
         n_cycles_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
`ifdef CMP_SIGNED_EN
                  signed_q <= signed_cmp;
`endif
                  idx_q    <= IW'(NCHUNK - 1);
                  cnt_q    <= '0;
                  a_gt_q   <= 1'b0;
                  b_gt_q   <= 1'b0;
                  a_eq_q   <= 1'b0;
                  state_q  <= S_CMP;
               end
            end
            S_CMP: begin
               cnt_q <= cnt_q + (IW+1)'(1);
               if (a_wins || b_wins) begin
                  a_gt_q      <= a_wins;
                  b_gt_q      <= b_wins;
                  a_eq_q      <= 1'b0;
                  n_cycles_q  <= cnt_q + (IW+1)'(1);
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else if (idx_q == '0) begin
                  a_gt_q      <= 1'b0;
                  b_gt_q      <= 1'b0;
                  a_eq_q      <= 1'b1;
                  n_cycles_q  <= cnt_q + (IW+1)'(1);
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  idx_q <= idx_q - IW'(1);
               end
            end
            S_DONE: begin
               // Returning to IDLE here leaves one bubble before the next accept.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign a_gt      = a_gt_q;
   assign b_gt      = b_gt_q;
   assign a_eq      = a_eq_q;
   assign n_cycles  = n_cycles_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator: driver pushes model results, monitor pops and compares.
// Signed-mode cases are included when CMP_SIGNED_EN is defined.
module tb_seq_magnitude_comparator;
   localparam int W  = 16;
   localparam int C  = 4;
   localparam int NC = W / C;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  a, b;
   logic          sgn;
   logic          a_gt, b_gt, a_eq;
   logic [2:0]    n_cycles;

   logic          in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]    a8, b8;
   logic          sgn8;
   logic          a_gt8, b_gt8, a_eq8;
   logic [1:0]    n_cycles8;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic gt;
      logic lt;
      logic eq;
      int   k;
      int   acc;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_magnitude_comparator #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
`ifdef CMP_SIGNED_EN
      .signed_cmp(sgn),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .a_gt(a_gt), .b_gt(b_gt), .a_eq(a_eq), .n_cycles(n_cycles)
   );

   seq_magnitude_comparator #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8),
`ifdef CMP_SIGNED_EN
      .signed_cmp(sgn8),
`endif
      .out_valid(out_valid8), .out_ready(out_ready8),
      .a_gt(a_gt8), .b_gt(b_gt8), .a_eq(a_eq8), .n_cycles(n_cycles8)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain comparison; k is the MSB-side chunk holding the highest differing bit.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t e;
      logic [W-1:0] d;
      bit found;
      d = x ^ y;
      found = 0;
      e.k = NC;
      for (int p = W - 1; p >= 0; p--) begin
         if (!found && d[p]) begin
            found = 1;
            e.k = NC - p / C;
         end
      end
      if (s) begin
         e.gt = ($signed(x) > $signed(y));
         e.lt = ($signed(x) < $signed(y));
      end else begin
         e.gt = (x > y);
         e.lt = (x < y);
      end
      e.eq = (x == y);
      e.acc = 0;
      return e;
   endfunction

   // Monitor: pops on the first cycle of each result, then checks the result holds.
   bit   in_txn = 0;
   exp_t cur;
   always @(negedge clk) begin
      if (!rst_n) begin
         in_txn = 0;
      end else if (out_valid) begin
         if (!in_txn) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
               cur = exp_q.pop_front();
               in_txn = 1;
               chk("a_gt", {31'd0, a_gt}, {31'd0, cur.gt});
               chk("b_gt", {31'd0, b_gt}, {31'd0, cur.lt});
               chk("a_eq", {31'd0, a_eq}, {31'd0, cur.eq});
               chk("n_cycles", {29'd0, n_cycles}, cur.k);
               chk("latency", cyc - cur.acc, cur.k);
            end
         end else begin
            chk("hold_flags", {29'd0, a_gt, b_gt, a_eq}, {29'd0, cur.gt, cur.lt, cur.eq});
            chk("hold_n_cycles", {29'd0, n_cycles}, cur.k);
         end
         chk("onehot", a_gt + b_gt + a_eq, 32'd1);
         if (out_ready) in_txn = 0;
      end
   end

   task automatic check_idle(input string nm);
      chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({nm, "_flags"}, {29'd0, a_gt, b_gt, a_eq}, 32'd0);
      chk({nm, "_n_cycles"}, {29'd0, n_cycles}, 32'd0);
      chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t e;
      int t;
      in_valid = 1'b1; a = x; b = y; sgn = s;
      t = 0;
      while (!in_ready && t < 50) begin
         tick();
         t++;
      end
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      e = model(x, y, s);
      e.acc = cyc + 1;
      exp_q.push_back(e);
      tick();
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      sgn = 1'($urandom);
   endtask

   task automatic finish_txn(input int hold);
      int t;
      t = 0;
      while (!out_valid && t < 3 * NC + 6) begin
         out_ready = 1'($urandom);
         in_valid  = 1'($urandom);
         a = W'($urandom);
         b = W'($urandom);
         tick();
         t++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("result_timeout", {31'd0, out_valid}, 32'd1);
      for (int h = 0; h < hold; h++) begin
         chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
         in_valid = 1'b1;
         a = W'($urandom);
         b = W'($urandom);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
      chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int hold);
      send(x, y, s);
      finish_txn(hold);
   endtask

   task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s,
                       input logic egt, input logic elt, input logic eeq);
      int t;
      in_valid8 = 1'b1; a8 = x; b8 = y; sgn8 = s;
      chk("w8_in_ready", {31'd0, in_ready8}, 32'd1);
      tick();
      in_valid8 = 1'b0;
      t = 0;
      while (!out_valid8 && t < 5) begin
         tick();
         t++;
      end
      chk("w8_latency", t, 32'd1);
      chk("w8_flags", {29'd0, a_gt8, b_gt8, a_eq8}, {29'd0, egt, elt, eeq});
      chk("w8_n_cycles", {30'd0, n_cycles8}, 32'd1);
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      chk("w8_post_out_valid", {31'd0, out_valid8}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] x, y;
      logic s;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sgn = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; sgn8 = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check_idle("reset");

      txn(16'h00FF, 16'h00FF, 1'b0, 0);
      txn(16'h7000, 16'h6FFF, 1'b0, 1);
      txn(16'h1234, 16'h1235, 1'b0, 0);
      txn(16'hABCD, 16'hABCD, 1'b0, 3);
      txn(16'h0000, 16'hFFFF, 1'b0, 0);

      // Abort a compare in flight; the scoreboard drops its pending entry.
      send(16'h1234, 16'h1235, 1'b0);
      tick();
      rst_n = 1'b0;
      tick();
      tick();
      exp_q.delete();
      rst_n = 1'b1;
      tick();
      check_idle("midreset");
      for (int i = 0; i < 6; i++) begin
         chk("midreset_no_valid", {31'd0, out_valid}, 32'd0);
         tick();
      end

`ifdef CMP_SIGNED_EN
      txn(16'hFFFF, 16'h0001, 1'b1, 0);
      txn(16'hFFFF, 16'h0001, 1'b0, 0);
      txn(16'h8000, 16'hFFFF, 1'b1, 1);
      run8(8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
      run8(8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
      run8(8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
      run8(8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);

      for (int n = 0; n < 60; n++) begin
         x = W'($urandom);
         y = x;
         if ($urandom_range(0, 4) == 0) begin
            y = W'($urandom);
         end else begin
            for (int i = 0; i < NC; i++) begin
               if ($urandom_range(0, 2) == 0) y[i*C +: C] = C'($urandom);
            end
         end
`ifdef CMP_SIGNED_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         txn(x, y, s, $urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) tick();
      end

      repeat (4) tick();
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
